// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for a 5-stage RV32 pipeline: freezes on memory busy, flushes on
// taken branches, and inserts one load-use bubble. Also keeps saturating hazard counters.
module pipeline_hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 branch_taken_i,
    input  logic                 ex_mem_read_i,
    input  logic [4:0]           ex_rd_i,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic                 id_uses_rs1_i,
    input  logic                 id_uses_rs2_i,
    input  logic                 imem_busy_i,
    input  logic                 dmem_busy_i,
    output logic                 pc_hold_o,
    output logic                 if_id_hold_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic                 pipe_freeze_o,
    output logic [CNT_WIDTH-1:0] flush_count_o,
    output logic [CNT_WIDTH-1:0] stall_count_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t               state_q, state_d;
    logic [2:0]           flush_left_q, flush_left_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic busy;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    assign busy     = imem_busy_i | dmem_busy_i;
    assign rs1_hit  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        state_d       = state_q;
        flush_left_d  = flush_left_q;
        flush_cnt_d   = flush_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        pc_hold_o     = 1'b0;
        if_id_hold_o  = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        pipe_freeze_o = 1'b0;

        // Reset overrides every control output combinationally, not just at the next edge.
        if (rst_i) begin
            pc_hold_o = 1'b0;
        end else if (busy) begin
            pipe_freeze_o = 1'b1;
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
            if (FLUSH_CYCLES > 1) begin
                state_d      = FLUSH;
                flush_left_d = FLUSH_RELOAD;
            end else begin
                state_d      = RUN;
                flush_left_d = 3'd0;
            end
        end else if (state_q == FLUSH) begin
            if_id_flush_o = 1'b1;
            flush_left_d  = flush_left_q - 3'd1;
            if (flush_left_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (load_use) begin
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            id_ex_flush_o = 1'b1;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            flush_left_q <= 3'd0;
            flush_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            flush_cnt_q  <= flush_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign flush_count_o = flush_cnt_q;
    assign stall_count_o = stall_cnt_q;

endmodule
